// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared encodings for the memory stage: load/store funct3
//                codes, LSU state encoding and size/alignment helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    // Load funct3 encodings; stores share the low two bits for access size
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // LSU bus FSM state encoding
    typedef logic [1:0] lsu_state_e;
    localparam lsu_state_e c_IDLE     = 2'd0;
    localparam lsu_state_e c_WAIT_GNT = 2'd1;
    localparam lsu_state_e c_WAIT_RSP = 2'd2;
    localparam lsu_state_e c_DRAIN    = 2'd3;

    // Byte mask for an access of the given size, anchored at lane 0
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        logic [7:0] m;
        case (size)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m;
    endfunction

    // Natural-alignment check; a doubleword on a 32-bit datapath cannot be
    // served by the bus and is trapped the same way
    function automatic logic is_misaligned(input logic [2:0] f3,
                                           input logic [2:0] addr_lo,
                                           input logic       is64);
        logic bad;
        case (f3[1:0])
            2'd0:    bad = 1'b0;
            2'd1:    bad = addr_lo[0];
            2'd2:    bad = |addr_lo[1:0];
            default: bad = (~is64) | (|addr_lo);
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational lane steering: store byte-enable / data shift
//                and load byte-lane extraction with sign or zero extension.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import riscv_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int NB    = XLEN / 8,
    localparam int OFF_W = $clog2(NB)
) (
    input  logic [1:0]       i_st_size,
    input  logic [OFF_W-1:0] i_st_off,
    input  logic [XLEN-1:0]  i_st_data,
    output logic [NB-1:0]    o_be,
    output logic [XLEN-1:0]  o_wdata,
    input  logic [2:0]       i_ld_f3,
    input  logic [OFF_W-1:0] i_ld_off,
    input  logic [XLEN-1:0]  i_rdata,
    output logic [XLEN-1:0]  o_ld_data
);

    logic [XLEN-1:0] w_sh;
    logic [XLEN-1:0] w_word_s;
    logic [XLEN-1:0] w_word_z;

    // Store: move the low-order data and its mask up to the addressed lane
    assign o_be    = NB'(size_mask(i_st_size)) << i_st_off;
    assign o_wdata = i_st_data << {i_st_off, 3'b000};

    // Load: bring the addressed lane down to bit 0 before extending
    assign w_sh = i_rdata >> {i_ld_off, 3'b000};

    // Word extension only differs from the raw value on a 64-bit datapath
    generate
        if (XLEN == 64) begin : g_x64
            assign w_word_s = {{32{w_sh[31]}}, w_sh[31:0]};
            assign w_word_z = {32'b0, w_sh[31:0]};
        end else begin : g_x32
            assign w_word_s = w_sh;
            assign w_word_z = w_sh;
        end
    endgenerate

    // Select the extension matching the load type
    always_comb begin
        o_ld_data = w_sh;
        case (i_ld_f3)
            F3_LB:   o_ld_data = {{(XLEN-8){w_sh[7]}}, w_sh[7:0]};
            F3_LH:   o_ld_data = {{(XLEN-16){w_sh[15]}}, w_sh[15:0]};
            F3_LW:   o_ld_data = w_word_s;
            F3_LD:   o_ld_data = w_sh;
            F3_LBU:  o_ld_data = {{(XLEN-8){1'b0}}, w_sh[7:0]};
            F3_LHU:  o_ld_data = {{(XLEN-16){1'b0}}, w_sh[15:0]};
            F3_LWU:  o_ld_data = w_word_z;
            default: o_ld_data = w_sh;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_lsu
//  Description : Memory stage with req/gnt/rvalid data bus, sub-word access,
//                misalignment trap, bus timeout, M-stage flush and the
//                MEM/WB pipeline register.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu
    import riscv_pkg::*;
#(
    parameter  int XLEN    = 32,
    parameter  int TIMEOUT = 64,
    localparam int CNT_W   = $clog2(TIMEOUT + 1),
    localparam int NB      = XLEN / 8,
    localparam int OFF_W   = $clog2(NB)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ValidM,
    input  logic            RegWriteM,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic [1:0]      ResultSrcM,
    input  logic [2:0]      Funct3M,
    input  logic [4:0]      RD_M,
    input  logic [XLEN-1:0] PCPlus4M,
    input  logic [XLEN-1:0] ALU_ResultM,
    input  logic [XLEN-1:0] WriteDataM,
    input  logic            FlushM,
    output logic            StallM,
    output logic            MisalignM,
    output logic            BusErrM,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [NB-1:0]   dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_gnt,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            ValidW,
    output logic            RegWriteW,
    output logic [1:0]      ResultSrcW,
    output logic [4:0]      RD_W,
    output logic [XLEN-1:0] PCPlus4W,
    output logic [XLEN-1:0] ALU_ResultW,
    output logic [XLEN-1:0] ReadDataW
);

    lsu_state_e       r_state;
    lsu_state_e       w_next;
    logic [CNT_W-1:0] r_cnt;

    // Request captured at issue so it stays stable while waiting for gnt,
    // and so the response is steered with the size/lane it was issued with
    logic [XLEN-1:0]  r_addr;
    logic [XLEN-1:0]  r_wdata;
    logic [NB-1:0]    r_be;
    logic             r_we;
    logic [2:0]       r_f3;
    logic [OFF_W-1:0] r_off;

    logic             w_mem_op;
    logic             w_misal;
    logic             w_tmo;
    logic             w_issue;
    logic             w_retire;
    logic             w_load_done;
    logic [XLEN-1:0]  w_addr_al;
    logic [NB-1:0]    w_al_be;
    logic [XLEN-1:0]  w_al_wdata;
    logic [XLEN-1:0]  w_ld_data;

    assign w_mem_op  = ValidM & (MemReadM | MemWriteM);
    assign w_misal   = is_misaligned(Funct3M, ALU_ResultM[2:0], XLEN == 64);
    assign w_tmo     = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_addr_al = {ALU_ResultM[XLEN-1:OFF_W], {OFF_W{1'b0}}};

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_st_size (Funct3M[1:0]),
        .i_st_off  (ALU_ResultM[OFF_W-1:0]),
        .i_st_data (WriteDataM),
        .o_be      (w_al_be),
        .o_wdata   (w_al_wdata),
        .i_ld_f3   (r_f3),
        .i_ld_off  (r_off),
        .i_rdata   (dmem_rdata),
        .o_ld_data (w_ld_data)
    );

    // Bus control, stall and next-state; a stall is released in the cycle the
    // M-stage instruction finishes (retire, bubble or flush), except in DRAIN,
    // where M already holds a younger instruction that has not been serviced
    always_comb begin
        w_next      = r_state;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        dmem_addr   = '0;
        dmem_be     = '0;
        dmem_wdata  = '0;
        StallM      = 1'b0;
        MisalignM   = 1'b0;
        BusErrM     = 1'b0;
        w_issue     = 1'b0;
        w_retire    = 1'b0;
        w_load_done = 1'b0;
        if (!rst) begin
            case (r_state)
                c_IDLE: begin
                    if (FlushM) begin
                        w_next = c_IDLE;
                    end else if (w_mem_op && w_misal) begin
                        MisalignM = 1'b1;
                    end else if (w_mem_op) begin
                        dmem_req   = 1'b1;
                        dmem_we    = MemWriteM;
                        dmem_addr  = w_addr_al;
                        dmem_be    = w_al_be;
                        dmem_wdata = MemWriteM ? w_al_wdata : '0;
                        w_issue    = 1'b1;
                        if (dmem_gnt && MemWriteM) begin
                            w_retire = 1'b1;
                        end else if (dmem_gnt) begin
                            w_next = c_WAIT_RSP;
                            StallM = 1'b1;
                        end else begin
                            w_next = c_WAIT_GNT;
                            StallM = 1'b1;
                        end
                    end else begin
                        w_retire = ValidM;
                    end
                end
                c_WAIT_GNT: begin
                    // Request stays asserted for the whole cycle; a grant
                    // arriving alongside a flush or timeout is honoured
                    dmem_req   = 1'b1;
                    dmem_we    = r_we;
                    dmem_addr  = r_addr;
                    dmem_be    = r_be;
                    dmem_wdata = r_wdata;
                    StallM     = 1'b1;
                    if (dmem_gnt && r_we) begin
                        w_retire = 1'b1;
                        StallM   = 1'b0;
                        w_next   = c_IDLE;
                    end else if (dmem_gnt && FlushM) begin
                        StallM = 1'b0;
                        w_next = c_DRAIN;
                    end else if (dmem_gnt) begin
                        w_next = c_WAIT_RSP;
                    end else if (FlushM) begin
                        StallM = 1'b0;
                        w_next = c_IDLE;
                    end else if (w_tmo) begin
                        BusErrM = 1'b1;
                        StallM  = 1'b0;
                        w_next  = c_IDLE;
                    end
                end
                c_WAIT_RSP: begin
                    StallM = 1'b1;
                    if (dmem_rvalid) begin
                        // Response consumed here even when flushed
                        StallM      = 1'b0;
                        w_next      = c_IDLE;
                        w_retire    = ~FlushM;
                        w_load_done = ~FlushM;
                    end else if (FlushM) begin
                        StallM = 1'b0;
                        w_next = c_DRAIN;
                    end else if (w_tmo) begin
                        BusErrM = 1'b1;
                        StallM  = 1'b0;
                        w_next  = c_DRAIN;
                    end
                end
                default: begin
                    StallM = 1'b1;
                    if (dmem_rvalid || w_tmo) begin
                        w_next = c_IDLE;
                    end
                end
            endcase
        end
    end

    // FSM state and wait counter; counter restarts whenever the state changes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if ((w_next != r_state) || (r_state == c_IDLE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Capture the issued request for the wait states
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_off   <= '0;
        end else if (w_issue) begin
            r_addr  <= w_addr_al;
            r_wdata <= MemWriteM ? w_al_wdata : '0;
            r_be    <= w_al_be;
            r_we    <= MemWriteM;
            r_f3    <= Funct3M;
            r_off   <= ALU_ResultM[OFF_W-1:0];
        end
    end

    // MEM/WB register; anything that does not retire becomes a bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ValidW      <= 1'b0;
            RegWriteW   <= 1'b0;
            ResultSrcW  <= '0;
            RD_W        <= '0;
            PCPlus4W    <= '0;
            ALU_ResultW <= '0;
            ReadDataW   <= '0;
        end else begin
            ValidW      <= w_retire;
            RegWriteW   <= w_retire & RegWriteM;
            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= w_load_done ? w_ld_data : '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_lsu
//  Description : Directed self-checking bench for mem_stage_lsu.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;
    import riscv_pkg::*;

    localparam int XLEN    = 32;
    localparam int TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidM, RegWriteM, MemReadM, MemWriteM, FlushM;
    logic [1:0]  ResultSrcM;
    logic [2:0]  Funct3M;
    logic [4:0]  RD_M;
    logic [31:0] PCPlus4M, ALU_ResultM, WriteDataM;
    logic        StallM, MisalignM, BusErrM;
    logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        ValidW, RegWriteW;
    logic [1:0]  ResultSrcW;
    logic [4:0]  RD_W;
    logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;

    int n_cmp = 0;
    int n_err = 0;
    int stall_cnt;

    mem_stage_lsu #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .ValidM(ValidM), .RegWriteM(RegWriteM),
        .MemReadM(MemReadM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .Funct3M(Funct3M), .RD_M(RD_M), .PCPlus4M(PCPlus4M),
        .ALU_ResultM(ALU_ResultM), .WriteDataM(WriteDataM), .FlushM(FlushM),
        .StallM(StallM), .MisalignM(MisalignM), .BusErrM(BusErrM),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .ValidW(ValidW), .RegWriteW(RegWriteW), .ResultSrcW(ResultSrcW),
        .RD_W(RD_W), .PCPlus4W(PCPlus4W), .ALU_ResultW(ALU_ResultW),
        .ReadDataW(ReadDataW)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input logic v, input logic rw, input logic mr, input logic mw,
                           input logic [2:0] f3, input logic [4:0] rd,
                           input logic [31:0] addr, input logic [31:0] data);
        ValidM      = v;
        RegWriteM   = rw;
        MemReadM    = mr;
        MemWriteM   = mw;
        Funct3M     = f3;
        RD_M        = rd;
        ALU_ResultM = addr;
        WriteDataM  = data;
        PCPlus4M    = addr + 32'd4;
        ResultSrcM  = mr ? 2'd1 : 2'd0;
    endtask

    task automatic idle_m();
        drive_m(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
        FlushM      = 1'b0;
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'd0;
    endtask

    // Load granted in its issue cycle, response on the following cycle
    task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [3:0] exp_be, input logic [31:0] rdata,
                           input logic [31:0] exp);
        drive_m(1'b1, 1'b1, 1'b1, 1'b0, f3, 5'd3, addr, 32'd0);
        dmem_gnt = 1'b1;
        @(negedge clk);
        chk_eq({tag, "_be"}, dmem_be, exp_be);
        tick();
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        @(negedge clk);
        chk_eq({tag, "_stall"}, StallM, 1'b0);
        tick();
        dmem_rvalid = 1'b0;
        chk_eq({tag, "_data"}, ReadDataW, exp);
        idle_m();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle_m();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_stall", StallM, 1'b0);
        chk_eq("rst_req", dmem_req, 1'b0);
        chk_eq("rst_validw", ValidW, 1'b0);
        chk_eq("rst_rdw", ReadDataW, 32'd0);
        tick();
        rst = 1'b0;

        // Non-memory op: one-cycle pass-through
        drive_m(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd5, 32'h1234, 32'd0);
        @(negedge clk);
        chk_eq("alu_stall", StallM, 1'b0);
        chk_eq("alu_req", dmem_req, 1'b0);
        tick();
        chk_eq("alu_validw", ValidW, 1'b1);
        chk_eq("alu_rdw", RD_W, 5'd5);
        chk_eq("alu_resw", ALU_ResultW, 32'h1234);
        chk_eq("alu_regwr", RegWriteW, 1'b1);
        idle_m();

        // LW 0x100, gnt in issue cycle, rvalid three cycles later
        drive_m(1'b1, 1'b1, 1'b1, 1'b0, F3_LW, 5'd4, 32'h100, 32'd0);
        dmem_gnt = 1'b1;
        @(negedge clk);
        chk_eq("lw_req", dmem_req, 1'b1);
        chk_eq("lw_addr", dmem_addr, 32'h100);
        chk_eq("lw_be", dmem_be, 4'hF);
        chk_eq("lw_we", dmem_we, 1'b0);
        stall_cnt = StallM ? 1 : 0;
        tick();
        dmem_gnt = 1'b0;
        chk_eq("lw_bubble", ValidW, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (StallM) stall_cnt++;
            tick();
        end
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEADBEEF;
        @(negedge clk);
        chk_eq("lw_stall_rel", StallM, 1'b0);
        tick();
        dmem_rvalid = 1'b0;
        chk_eq("lw_stall_cnt", stall_cnt, 3);
        chk_eq("lw_data", ReadDataW, 32'hDEADBEEF);
        chk_eq("lw_regwr", RegWriteW, 1'b1);
        chk_eq("lw_validw", ValidW, 1'b1);
        idle_m();

        // Sub-word loads
        do_load("lb",  F3_LB,  32'h103, 4'b1000, 32'h80123456, 32'hFFFFFF80);
        do_load("lbu", F3_LBU, 32'h103, 4'b1000, 32'h80123456, 32'h00000080);
        do_load("lh",  F3_LH,  32'h102, 4'b1100, 32'h80123456, 32'hFFFF8012);
        do_load("lhu", F3_LHU, 32'h102, 4'b1100, 32'h7FFF0000, 32'h00007FFF);
        do_load("lbp", F3_LB,  32'h101, 4'b0010, 32'h00007F00, 32'h0000007F);

        // SH 0x102: lane-shifted store, retires in one cycle
        drive_m(1'b1, 1'b0, 1'b0, 1'b1, 3'b001, 5'd0, 32'h102, 32'hABCD1234);
        dmem_gnt = 1'b1;
        @(negedge clk);
        chk_eq("sh_be", dmem_be, 4'b1100);
        chk_eq("sh_wdata", dmem_wdata, 32'h12340000);
        chk_eq("sh_addr", dmem_addr, 32'h100);
        chk_eq("sh_we", dmem_we, 1'b1);
        chk_eq("sh_stall", StallM, 1'b0);
        tick();
        chk_eq("sh_validw", ValidW, 1'b1);
        chk_eq("sh_regwr", RegWriteW, 1'b0);
        drive_m(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 5'd0, 32'h101, 32'h00000055);
        @(negedge clk);
        chk_eq("sb_be", dmem_be, 4'b0010);
        chk_eq("sb_wdata", dmem_wdata, 32'h00005500);
        tick();
        idle_m();

        // Misaligned accesses
        drive_m(1'b1, 1'b1, 1'b1, 1'b0, F3_LW, 5'd6, 32'h101, 32'd0);
        @(negedge clk);
        chk_eq("mis_flag", MisalignM, 1'b1);
        chk_eq("mis_req", dmem_req, 1'b0);
        chk_eq("mis_stall", StallM, 1'b0);
        tick();
        chk_eq("mis_validw", ValidW, 1'b0);
        drive_m(1'b1, 1'b1, 1'b1, 1'b0, F3_LH, 5'd6, 32'h103, 32'd0);
        @(negedge clk);
        chk_eq("mis_lh", MisalignM, 1'b1);
        tick();
        idle_m();
        @(negedge clk);
        chk_eq("mis_pulse", MisalignM, 1'b0);
        tick();

        // Grant timeout: TIMEOUT cycles in WAIT_GNT
        drive_m(1'b1, 1'b1, 1'b1, 1'b0, F3_LW, 5'd8, 32'h200, 32'd0);
        @(negedge clk);
        chk_eq("tmo_stall0", StallM, 1'b1);
        tick();
        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge clk);
            chk_eq("tmo_buserr", BusErrM, (k == TIMEOUT - 1) ? 1'b1 : 1'b0);
            if (k == 1) chk_eq("tmo_addr_held", dmem_addr, 32'h200);
            if (k == TIMEOUT - 1) chk_eq("tmo_stall_rel", StallM, 1'b0);
            tick();
        end
        chk_eq("tmo_validw", ValidW, 1'b0);
        idle_m();
        @(negedge clk);
        chk_eq("tmo_req_drop", dmem_req, 1'b0);
        chk_eq("tmo_pulse", BusErrM, 1'b0);
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h12345678;
        tick();
        dmem_rvalid = 1'b0;
        chk_eq("tmo_late_valid", ValidW, 1'b0);
        chk_eq("tmo_late_data", ReadDataW, 32'd0);

        // Flush while waiting for the response, then drain it
        drive_m(1'b1, 1'b1, 1'b1, 1'b0, F3_LW, 5'd9, 32'h300, 32'd0);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        FlushM   = 1'b1;
        @(negedge clk);
        chk_eq("fl_stall", StallM, 1'b0);
        tick();
        chk_eq("fl_validw", ValidW, 1'b0);
        FlushM = 1'b0;
        drive_m(1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'd7, 32'h77, 32'd0);
        @(negedge clk);
        chk_eq("drain_stall", StallM, 1'b1);
        chk_eq("drain_req", dmem_req, 1'b0);
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5555;
        @(negedge clk);
        chk_eq("drain_stall2", StallM, 1'b1);
        tick();
        dmem_rvalid = 1'b0;
        chk_eq("drain_validw", ValidW, 1'b0);
        chk_eq("drain_data", ReadDataW, 32'd0);
        @(negedge clk);
        chk_eq("drain_done", StallM, 1'b0);
        tick();
        chk_eq("drain_next_v", ValidW, 1'b1);
        chk_eq("drain_next_rd", RD_W, 5'd7);
        idle_m();

        // Store waiting for grant keeps its request stable
        drive_m(1'b1, 1'b0, 1'b0, 1'b1, 3'b010, 5'd0, 32'h400, 32'hAABBCCDD);
        @(negedge clk);
        chk_eq("swg_stall", StallM, 1'b1);
        tick();
        dmem_gnt = 1'b1;
        @(negedge clk);
        chk_eq("swg_req", dmem_req, 1'b1);
        chk_eq("swg_wdata", dmem_wdata, 32'hAABBCCDD);
        chk_eq("swg_stall_rel", StallM, 1'b0);
        tick();
        dmem_gnt = 1'b0;
        chk_eq("swg_validw", ValidW, 1'b1);
        idle_m();

        // Reset in the middle of a load wait
        drive_m(1'b1, 1'b1, 1'b1, 1'b0, F3_LW, 5'd9, 32'h500, 32'd0);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        @(negedge clk);
        chk_eq("rmw_stall", StallM, 1'b1);
        tick();
        chk_eq("rmw_rd_pre", RD_W, 5'd9);
        rst = 1'b1;
        #1;
        chk_eq("rmw_stall0", StallM, 1'b0);
        chk_eq("rmw_req0", dmem_req, 1'b0);
        chk_eq("rmw_rd0", RD_W, 5'd0);
        chk_eq("rmw_pc0", PCPlus4W, 32'd0);
        tick();
        idle_m();
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
